// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encodings and timeout defaults for the transmitter arbiter
package uart_tx_arbiter_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_GRANT   = 3'b001,
        ST_WAIT_HI = 3'b010,
        ST_WAIT_LO = 3'b011
    } state_t;
    localparam int IDLE_TIMEOUT_DEF = 255;
    localparam int BUSY_WAIT_DEF    = 4;
    localparam int CW_DEF           = 8;
endpackage

// File: rtl/uart_tx_arb_timer.sv
// uart_tx_arb_timer: saturating counter with clear/enable and terminal-count compare against a runtime limit
module uart_tx_arb_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_limit,
    output logic          o_tc
);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end
    assign o_tc = r_cnt == i_limit;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of one RS232 transmitter between two byte requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int BUSY_WAIT    = BUSY_WAIT_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       valid0,
    input  logic [7:0] data0,
    input  logic       last0,
    input  logic       req1,
    input  logic       valid1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic       txena,
    output logic [7:0] txdw,
    input  logic       txbusy,
    input  logic       err_clr,
    output logic       err_timeout,
    output logic       err_nobusy,
    output logic [2:0] sleds
);
    state_t        r_state;
    logic          r_owner, r_rr_last, r_last_q;
    logic          r_gnt0, r_gnt1, r_ack0, r_ack1, r_txena;
    logic          r_err_timeout, r_err_nobusy;
    logic [7:0]    r_txdw;
    logic          w_req, w_valid, w_last, w_pick;
    logic          w_acc, w_fin, w_tmo, w_rel, w_clr, w_en, w_tc;
    logic [7:0]    w_data;
    logic [CW-1:0] w_limit;

    assign w_req   = r_owner ? req1 : req0;
    assign w_valid = r_owner ? valid1 : valid0;
    assign w_data  = r_owner ? data1 : data0;
    assign w_last  = r_owner ? last1 : last0;
    assign w_pick  = (req0 && req1) ? !r_rr_last : req1;
    // a byte is only accepted while the transmitter is idle, so txena never overlaps txbusy
    assign w_acc   = r_state == ST_GRANT && w_req && w_valid && !txbusy;
    assign w_fin   = !txbusy && (r_state == ST_WAIT_LO || (r_state == ST_WAIT_HI && w_tc));
    assign w_tmo   = r_state == ST_GRANT && w_req && !w_acc && w_tc;
    assign w_rel   = (r_state == ST_GRANT && !w_req) || w_tmo || (w_fin && (r_last_q || !w_req));
    assign w_clr   = r_state == ST_IDLE || r_state == ST_WAIT_LO || w_acc || w_fin ||
                     (r_state == ST_WAIT_HI && txbusy);
    assign w_en    = (r_state == ST_GRANT && w_req) || r_state == ST_WAIT_HI;
    assign w_limit = r_state == ST_GRANT ? CW'(IDLE_TIMEOUT - 1) : CW'(BUSY_WAIT - 1);

    uart_tx_arb_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_rr_last     <= 1'b1;
            r_last_q      <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_txena       <= 1'b0;
            r_txdw        <= '0;
            r_err_timeout <= 1'b0;
            r_err_nobusy  <= 1'b0;
        end else begin
            r_ack0        <= w_acc && !r_owner;
            r_ack1        <= w_acc && r_owner;
            r_txena       <= w_acc;
            r_err_timeout <= w_tmo || (r_err_timeout && !err_clr);
            r_err_nobusy  <= (r_state == ST_WAIT_HI && w_fin) || (r_err_nobusy && !err_clr);
            case (r_state)
                ST_IDLE: if (req0 || req1) begin
                    r_owner <= w_pick;
                    r_gnt0  <= !w_pick;
                    r_gnt1  <= w_pick;
                    r_state <= ST_GRANT;
                end
                ST_GRANT: if (w_acc) begin
                    r_txdw   <= w_data;
                    r_last_q <= w_last;
                    r_state  <= ST_WAIT_HI;
                end
                ST_WAIT_HI: if (txbusy) r_state <= ST_WAIT_LO;
                ST_WAIT_LO: ;
                default: r_state <= ST_IDLE;
            endcase
            if (w_fin)
                r_state <= ST_GRANT;
            // release overrides the byte-done path: burst over, requester gone or stalled
            if (w_rel) begin
                r_state   <= ST_IDLE;
                r_gnt0    <= 1'b0;
                r_gnt1    <= 1'b0;
                r_rr_last <= r_owner;
            end
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign txena       = r_txena;
    assign txdw        = r_txdw;
    assign err_timeout = r_err_timeout;
    assign err_nobusy  = r_err_nobusy;
    assign sleds       = r_state;
endmodule
